rx_bit_timer: RTL
=================

// Module: rx_bit_timer
// PURPOSE
//  Timing controller for the serial receiver. Sequences two flex_counter instances:
//  a clocks-per-bit phase counter and a bits-per-byte counter. Produces a one-cycle
//  mid-bit sample strobe and a byte-complete pulse for the receive FSM/shift register.
//  Re-aligns bit phase on every detected data edge (d_edge) to absorb clock drift.
// PARAMETERS
//  CNT_BITS       4  width of both counters and bit_index
//  CLKS_PER_BIT   8  clocks per serial bit; 2..2**CNT_BITS-1
//  SAMPLE_POINT   3  phase count at which shift_strobe fires; 1..CLKS_PER_BIT
//  BITS_PER_BYTE  8  strobes per byte; 2..2**CNT_BITS-1
// PORTS
//  clk            in   1         system clock, rising edge
//  n_rst          in   1         asynchronous active-low reset
//  enable_timer   in   1         receive FSM request; level, held for whole packet
//  d_edge         in   1         one-cycle pulse: transition detected on line data
//  shift_strobe   out  1         one-cycle pulse: sample/shift the current bit now
//  byte_received  out  1         one-cycle registered pulse: BITS_PER_BYTE bits shifted
//  bit_index      out  CNT_BITS  bits shifted in current byte, 0..BITS_PER_BYTE
//  busy           out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE, both counters 0, every output 0.
//  States: IDLE -> ARM when enable_timer=1; ARM -> RUN when d_edge=1 (enable_timer=1);
//   ARM/RUN -> IDLE at the first edge sampling enable_timer=0 (priority over d_edge).
//  Phase counter P: rollover_val=CLKS_PER_BIT, count_enable=(state==RUN),
//   clear=(state!=RUN) | (state==RUN & d_edge). Clear beats enable.
//   Sequence after entry to RUN at edge E0: P=0 through E0, P=k after edge E0+k,
//   then wraps CLKS_PER_BIT -> 1 (flex_counter semantics, never back to 0 unless cleared).
//  shift_strobe = (state==RUN) & (P==SAMPLE_POINT); decoded from registered P, glitch-free,
//   exactly one cycle per bit. First strobe is the cycle after edge E0+SAMPLE_POINT,
//   then every CLKS_PER_BIT cycles.
//  Resync: d_edge in RUN clears P at that edge; next strobe is SAMPLE_POINT edges later.
//   d_edge in the same cycle as shift_strobe: strobe still valid that cycle, B still counts.
//  Bit counter B: rollover_val=BITS_PER_BYTE, count_enable=shift_strobe,
//   clear=(state!=RUN). bit_index=B: reaches BITS_PER_BYTE on 8th strobe edge,
//   next strobe wraps it to 1.
//  byte_received <= (state==RUN) & shift_strobe & (B==BITS_PER_BYTE-1); high exactly
//   the one cycle in which bit_index==BITS_PER_BYTE first appears.
//  enable_timer drop mid-byte: partial byte discarded; next edge -> IDLE, P=B=0, no
//   further strobes/pulses. Re-enable restarts from ARM.
//  d_edge in IDLE ignored; in ARM only causes ARM->RUN. No counter ever exceeds rollover.
// STRUCTURE
//  Package rx_timer_pkg: typedef enum logic [1:0] {IDLE, ARM, RUN} rx_timer_state_t;
//   default constants for CLKS_PER_BIT, SAMPLE_POINT, BITS_PER_BYTE.
//  Sub-module: flex_counter (existing, NUM_CNT_BITS=CNT_BITS) instantiated twice
//   (phase, bit). This block owns only state register, byte_received flop, decode.
// TESTING
//  1 Async reset mid-RUN (bit_index=4) -> all outputs 0 immediately, state IDLE, busy=0.
//  2 enable_timer=1, d_edge at edge E0 (defaults) -> strobes after E3,E11,...,E59;
//    byte_received and bit_index=8 after E60 only; strobe after E67 -> bit_index=1.
//  3 Resync: d_edge while P=6 -> P=0 next cycle, next strobe exactly 3 edges later;
//    d_edge coincident with strobe -> strobe counted, bit_index increments once.
//  4 enable_timer dropped at bit_index=5 -> next edge IDLE, bit_index=0, no strobes
//    over 20 clocks; re-enable + d_edge -> byte completes after 8 fresh strobes.
//  5 d_edge pulses in IDLE and enable held without d_edge -> no strobes, busy=1 in ARM only.
//  6 Params CLKS_PER_BIT=5, SAMPLE_POINT=2, BITS_PER_BYTE=4 -> strobe period 5,
//    first strobe after E2, byte_received after E18.

Source files
------------

// File: rtl/rx_timer_pkg.sv
// Shared types and default timing constants for the serial receive bit timer.
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } rx_timer_state_t;

  localparam int DEF_CNT_BITS      = 4;
  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_POINT  = 3;
  localparam int DEF_BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 1..rollover_val and wraps back to 1; only clear returns it to 0.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Clear has priority over enable.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: phase counter gives a mid-bit shift strobe, bit counter gives
// byte completion; any data edge while running re-aligns the bit phase.
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CNT_BITS      = DEF_CNT_BITS,
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable_timer,
  input  logic                d_edge,
  output logic                shift_strobe,
  output logic                byte_received,
  output logic [CNT_BITS-1:0] bit_index,
  output logic                busy,
  output rx_timer_state_t     dbg_state
);

  localparam logic [CNT_BITS-1:0] CPB_VAL    = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] SAMPLE_VAL = CNT_BITS'(SAMPLE_POINT);
  localparam logic [CNT_BITS-1:0] BPB_VAL    = CNT_BITS'(BITS_PER_BYTE);
  localparam logic [CNT_BITS-1:0] LAST_BIT   = CNT_BITS'(BITS_PER_BYTE - 1);

  rx_timer_state_t     state_q;
  rx_timer_state_t     state_d;
  logic                byte_received_q;
  logic                byte_received_d;
  logic [CNT_BITS-1:0] phase_cnt;
  logic [CNT_BITS-1:0] bit_cnt;
  logic                running;
  logic                phase_clear;
  logic                bit_clear;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable_timer) state_d = ARM;
      ARM: begin
        if (!enable_timer) begin
          state_d = IDLE;
        end else if (d_edge) begin
          state_d = RUN;
        end
      end
      RUN: if (!enable_timer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      byte_received_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_received_q <= byte_received_d;
    end
  end

  assign running = (state_q == RUN);

  // Counters are also cleared on the edge that leaves RUN, so they read 0
  // from the first IDLE cycle and a partial byte is dropped at once.
  assign phase_clear = !running || d_edge || !enable_timer;
  assign bit_clear   = !running || !enable_timer;

  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_phase_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (phase_clear),
    .count_enable(running),
    .rollover_val(CPB_VAL),
    .count_out   (phase_cnt)
  );

  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_bit_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (bit_clear),
    .count_enable(shift_strobe),
    .rollover_val(BPB_VAL),
    .count_out   (bit_cnt)
  );

  // Decoded from registered state only, so the strobe is glitch-free.
  assign shift_strobe    = running && (phase_cnt == SAMPLE_VAL);
  assign byte_received_d = running && enable_timer && shift_strobe && (bit_cnt == LAST_BIT);

  assign byte_received = byte_received_q;
  assign bit_index     = bit_cnt;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
